// File: rtl/bbox_overlay.sv
// bbox_overlay: collects 16 prediction boxes from the wrapper byte stream into a shadow
// table, swaps it in at frame start, and draws box outlines. Option macro: BBOX_LABEL_COLOR_EN.
module bbox_overlay #(
  parameter int unsigned THICK = 2,
  parameter logic [7:0]  BOX_R = 8'd255,
  parameter logic [7:0]  BOX_G = 8'd0,
  parameter logic [7:0]  BOX_B = 8'd0,
  parameter int unsigned H_MAX = 639,
  parameter int unsigned V_MAX = 479
) (
  input  logic       avm_clk,
  input  logic       avm_rst_n,
  input  logic       i_seq_start,
  input  logic [7:0] i_pred_data,
  input  logic       i_pred_valid,
  input  logic       i_frame_start,
  input  logic [9:0] i_vga_h,
  input  logic [9:0] i_vga_v,
  input  logic       i_vga_valid,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic       o_vga_valid,
  output logic [6:0] o_byte_cnt,
  output logic       o_table_ready,
  output logic [4:0] o_num_boxes
);

  localparam int unsigned NB = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned AW = 11;
  localparam logic [AW-1:0] T1 = AW'(THICK - 1);
  localparam logic [CW-1:0] HM = CW'(H_MAX);
  localparam logic [CW-1:0] VM = CW'(V_MAX);

  logic [CW-1:0] sh_tab  [NB][4];
  logic [CW-1:0] act_tab [NB][4];
  logic [NB-1:0] sh_vld_c;
  logic [NB-1:0] act_vld;
  logic [4:0]    sh_cnt_c;
  logic [1:0]    hi_q;
  logic          pending;
  logic          swap_c;
  logic [CW-1:0] raw_c;
  logic [CW-1:0] coord_c;
  logic [NB-1:0] hit_c;
  logic [NB-1:0] hit_q;
  logic [7:0]    pix_r_q, pix_g_q, pix_b_q;
  logic          valid_q;
  logic [7:0]    box_r_c, box_g_c, box_b_c;

  function automatic logic in_rng(input logic [AW-1:0] p, input logic [AW-1:0] lo,
                                  input logic [AW-1:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction

  // p lies in the THICK-wide band at either end of [lo,hi]; no wrap at 11 bits
  function automatic logic in_band(input logic [AW-1:0] p, input logic [AW-1:0] lo,
                                   input logic [AW-1:0] hi);
    return ((p >= lo) && (p <= lo + T1)) || ((p + T1 >= hi) && (p <= hi));
  endfunction

  assign swap_c = i_frame_start & pending;

  // Even byte index within a box is the high half, odd completes the coordinate
  always_comb begin
    raw_c = {hi_q, i_pred_data};
    if (!o_byte_cnt[1]) coord_c = (raw_c > HM) ? HM : raw_c;
    else                coord_c = (raw_c > VM) ? VM : raw_c;
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      o_byte_cnt <= '0;
      hi_q       <= '0;
      pending    <= 1'b0;
      for (int k = 0; k < int'(NB); k++)
        for (int c = 0; c < 4; c++) sh_tab[k][c] <= '0;
    end else if (i_seq_start) begin
      o_byte_cnt <= '0;
      pending    <= 1'b0;
    end else begin
      if (i_pred_valid) begin
        o_byte_cnt <= o_byte_cnt + 7'd1;
        if (o_byte_cnt[0]) sh_tab[o_byte_cnt[6:3]][o_byte_cnt[2:1]] <= coord_c;
        else               hi_q <= i_pred_data[1:0];
      end
      if (i_pred_valid && (o_byte_cnt == 7'd127)) pending <= 1'b1;
      else if (swap_c)                           pending <= 1'b0;
    end
  end

  always_comb begin
    sh_cnt_c = '0;
    for (int k = 0; k < int'(NB); k++) begin
      sh_vld_c[k] = (sh_tab[k][0] <= sh_tab[k][2]) && (sh_tab[k][1] <= sh_tab[k][3]) &&
                    ((sh_tab[k][0] | sh_tab[k][1] | sh_tab[k][2] | sh_tab[k][3]) != '0);
      sh_cnt_c    = sh_cnt_c + 5'(sh_vld_c[k]);
    end
  end

  // Active table only changes on a frame boundary
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      act_vld       <= '0;
      o_num_boxes   <= '0;
      o_table_ready <= 1'b0;
      for (int k = 0; k < int'(NB); k++)
        for (int c = 0; c < 4; c++) act_tab[k][c] <= '0;
    end else if (swap_c) begin
      act_tab       <= sh_tab;
      act_vld       <= sh_vld_c;
      o_num_boxes   <= sh_cnt_c;
      o_table_ready <= 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NB); k++) begin
      hit_c[k] = act_vld[k] &&
        ((in_rng({1'b0, i_vga_h}, {1'b0, act_tab[k][0]}, {1'b0, act_tab[k][2]}) &&
          in_band({1'b0, i_vga_v}, {1'b0, act_tab[k][1]}, {1'b0, act_tab[k][3]})) ||
         (in_rng({1'b0, i_vga_v}, {1'b0, act_tab[k][1]}, {1'b0, act_tab[k][3]}) &&
          in_band({1'b0, i_vga_h}, {1'b0, act_tab[k][0]}, {1'b0, act_tab[k][2]})));
    end
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      hit_q   <= '0;
      pix_r_q <= '0;
      pix_g_q <= '0;
      pix_b_q <= '0;
      valid_q <= 1'b0;
    end else begin
      hit_q   <= hit_c;
      pix_r_q <= i_r;
      pix_g_q <= i_g;
      pix_b_q <= i_b;
      valid_q <= i_vga_valid;
    end
  end

`ifdef BBOX_LABEL_COLOR_EN
  logic [1:0] sel_c;

  // Lowest-index hitting box picks the palette entry
  always_comb begin
    sel_c = '0;
    for (int k = int'(NB) - 1; k >= 0; k--)
      if (hit_q[k]) sel_c = 2'(k);
  end

  always_comb begin
    box_r_c = 8'd255;
    box_g_c = 8'd0;
    box_b_c = 8'd0;
    case (sel_c)
      2'd1:    begin box_r_c = 8'd0;   box_g_c = 8'd255; box_b_c = 8'd0;   end
      2'd2:    begin box_r_c = 8'd0;   box_g_c = 8'd0;   box_b_c = 8'd255; end
      2'd3:    begin box_r_c = 8'd255; box_g_c = 8'd255; box_b_c = 8'd0;   end
      default: begin box_r_c = 8'd255; box_g_c = 8'd0;   box_b_c = 8'd0;   end
    endcase
  end
`else
  assign box_r_c = BOX_R;
  assign box_g_c = BOX_G;
  assign box_b_c = BOX_B;
`endif

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      o_r         <= '0;
      o_g         <= '0;
      o_b         <= '0;
      o_vga_valid <= 1'b0;
    end else begin
      o_vga_valid <= valid_q;
      if (valid_q && (hit_q != '0)) begin
        o_r <= box_r_c;
        o_g <= box_g_c;
        o_b <= box_b_c;
      end else begin
        o_r <= pix_r_q;
        o_g <= pix_g_q;
        o_b <= pix_b_q;
      end
    end
  end

endmodule

// File: tb/tb_bbox_overlay.sv
// Directed bench for bbox_overlay: a box-list model predicts every output each cycle,
// plus hand-computed spot checks on outline pixels and table swap timing.
module tb_bbox_overlay;

  localparam int T = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seq_start = 1'b0;
  logic [7:0] pred_data = '0;
  logic       pred_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] vga_h = '0, vga_v = '0;
  logic       vga_valid = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic [7:0] out_r, out_g, out_b;
  logic       out_valid;
  logic [6:0] byte_cnt;
  logic       table_ready;
  logic [4:0] num_boxes;

  int total = 0;
  int bad = 0;

  bbox_overlay dut (
    .avm_clk(clk), .avm_rst_n(rst_n), .i_seq_start(seq_start),
    .i_pred_data(pred_data), .i_pred_valid(pred_valid), .i_frame_start(frame_start),
    .i_vga_h(vga_h), .i_vga_v(vga_v), .i_vga_valid(vga_valid),
    .i_r(in_r), .i_g(in_g), .i_b(in_b),
    .o_r(out_r), .o_g(out_g), .o_b(out_b), .o_vga_valid(out_valid),
    .o_byte_cnt(byte_cnt), .o_table_ready(table_ready), .o_num_boxes(num_boxes)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Outline colour for box k in the current build
  function automatic int col(input int k);
`ifdef BBOX_LABEL_COLOR_EN
    case (k % 4)
      0: return 32'hFF0000;
      1: return 32'h00FF00;
      2: return 32'h0000FF;
      default: return 32'hFFFF00;
    endcase
`else
    return 32'hFF0000 + (k * 0);
`endif
  endfunction

  // ---------------- model: box lists, byte pointer, pending flag ----------------
  int  m_sh [16][4];
  int  m_act[16][4];
  int  m_ptr, m_hi, m_num;
  bit  m_pend, m_ready;
  int  e1_r, e1_g, e1_b, e1_v, e2_r, e2_g, e2_b, e2_v;

  function automatic bit box_ok(input int x0, input int y0, input int x1, input int y1);
    return (x0 <= x1) && (y0 <= y1) && !(x0 == 0 && y0 == 0 && x1 == 0 && y1 == 0);
  endfunction

  function automatic int hitk(input int h, input int v);
    for (int k = 0; k < 16; k++) begin
      int x0, y0, x1, y1;
      bit rowb, colb;
      x0 = m_act[k][0]; y0 = m_act[k][1]; x1 = m_act[k][2]; y1 = m_act[k][3];
      if (!box_ok(x0, y0, x1, y1)) continue;
      rowb = (v >= y0 && v <= y0 + T - 1) || (v >= y1 - T + 1 && v <= y1);
      colb = (h >= x0 && h <= x0 + T - 1) || (h >= x1 - T + 1 && h <= x1);
      if ((h >= x0 && h <= x1 && rowb) || (v >= y0 && v <= y1 && colb)) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_sh[k, c]) begin m_sh[k][c] = 0; m_act[k][c] = 0; end
      m_ptr = 0; m_hi = 0; m_num = 0; m_pend = 0; m_ready = 0;
      e1_r = 0; e1_g = 0; e1_b = 0; e1_v = 0;
      e2_r = 0; e2_g = 0; e2_b = 0; e2_v = 0;
    end else begin
      int k, c, val;
      bit swapped;
      e2_r = e1_r; e2_g = e1_g; e2_b = e1_b; e2_v = e1_v;
      k = hitk(int'(vga_h), int'(vga_v));
      e1_v = int'(vga_valid);
      if (vga_valid && k >= 0) begin
        c = col(k);
        e1_r = (c >> 16) & 255; e1_g = (c >> 8) & 255; e1_b = c & 255;
      end else begin
        e1_r = int'(in_r); e1_g = int'(in_g); e1_b = int'(in_b);
      end
      swapped = frame_start && m_pend;
      if (swapped) begin
        m_act = m_sh;
        m_ready = 1;
        m_num = 0;
        for (int j = 0; j < 16; j++)
          if (box_ok(m_sh[j][0], m_sh[j][1], m_sh[j][2], m_sh[j][3])) m_num++;
      end
      if (seq_start) begin
        m_ptr = 0; m_pend = 0;
      end else begin
        if (pred_valid) begin
          if (m_ptr % 2 == 0) m_hi = int'(pred_data);
          else begin
            val = (m_hi * 256 + int'(pred_data)) % 1024;
            c = (m_ptr % 8) / 2;
            if (c % 2 == 0 && val > 639) val = 639;
            if (c % 2 == 1 && val > 479) val = 479;
            m_sh[m_ptr / 8][c] = val;
          end
        end
        if (pred_valid && m_ptr == 127) m_pend = 1;
        else if (swapped) m_pend = 0;
        if (pred_valid) m_ptr = (m_ptr + 1) % 128;
      end
    end
    #1;
    cmp("o_r", int'(out_r), e2_r);
    cmp("o_g", int'(out_g), e2_g);
    cmp("o_b", int'(out_b), e2_b);
    cmp("o_vga_valid", int'(out_valid), e2_v);
    cmp("o_byte_cnt", int'(byte_cnt), m_ptr);
    cmp("o_table_ready", int'(table_ready), int'(m_ready));
    cmp("o_num_boxes", int'(num_boxes), m_num);
  end

  // ---------------- stimulus helpers (all start and end at a negedge) ----------------
  int tbl[16][4];

  task automatic clr_tbl();
    foreach (tbl[k, c]) tbl[k][c] = 0;
  endtask

  task automatic set_box(input int k, input int x0, input int y0, input int x1, input int y1);
    tbl[k][0] = x0; tbl[k][1] = y0; tbl[k][2] = x1; tbl[k][3] = y1;
  endtask

  task automatic send_byte(input int d, input bit fs, input bit ss);
    pred_data = 8'(d); pred_valid = 1'b1; frame_start = fs; seq_start = ss;
    vga_h = 10'($urandom_range(0, 260)); vga_v = 10'($urandom_range(0, 260));
    vga_valid = 1'($urandom_range(0, 1));
    in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
    @(negedge clk);
    pred_valid = 1'b0; frame_start = 1'b0; seq_start = 1'b0;
  endtask

  function automatic int byte_of(input int i);
    int v;
    v = tbl[i / 8][(i % 8) / 2];
    return (i % 2 == 1) ? (v & 255) : ((v >> 8) & 255);
  endfunction

  task automatic send_tbl(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(byte_of(i), 1'b0, 1'b0);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0; @(negedge clk);
  endtask

  task automatic chk_pix(input string name, input int h, input int v, input bit vld,
                         input int er, input int eg, input int eb);
    vga_h = 10'(h); vga_v = 10'(v); vga_valid = vld;
    in_r = 8'd1; in_g = 8'd2; in_b = 8'd3;
    @(negedge clk);
    vga_valid = 1'b0;
    @(posedge clk); #1;
    cmp({name, ".r"}, int'(out_r), er);
    cmp({name, ".g"}, int'(out_g), eg);
    cmp({name, ".b"}, int'(out_b), eb);
    cmp({name, ".valid"}, int'(out_valid), int'(vld));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-stream after 40 bytes
    clr_tbl();
    set_box(0, 10, 20, 100, 200);
    send_tbl(0, 39);
    cmp("cnt_after_40", int'(byte_cnt), 40);
    rst_n = 1'b0;
    #1;
    cmp("rst_cnt", int'(byte_cnt), 0);
    cmp("rst_ready", int'(table_ready), 0);
    cmp("rst_r", int'(out_r), 0);
    cmp("rst_valid", int'(out_valid), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_pix("pass_after_rst", 10, 50, 1'b1, 1, 2, 3);

    // Table A: box0 (10,20,100,200)
    send_tbl(0, 127);
    cmp("a_no_swap_yet", int'(num_boxes), 0);
    pulse_fs();
    cmp("a_num", int'(num_boxes), 1);
    cmp("a_ready", int'(table_ready), 1);
    chk_pix("a_10_50", 10, 50, 1'b1, 255, 0, 0);
    chk_pix("a_11_50", 11, 50, 1'b1, 255, 0, 0);
    chk_pix("a_12_50", 12, 50, 1'b1, 1, 2, 3);
    chk_pix("a_50_50", 50, 50, 1'b1, 1, 2, 3);
    chk_pix("a_50_21", 50, 21, 1'b1, 255, 0, 0);
    chk_pix("a_50_22", 50, 22, 1'b1, 1, 2, 3);
    chk_pix("a_100_199", 100, 199, 1'b1, 255, 0, 0);
    chk_pix("a_invalid_px", 10, 50, 1'b0, 1, 2, 3);

    // Table B: clamped box0, box1, invalid box3; last byte coincides with frame_start
    clr_tbl();
    set_box(0, 0, 0, 16'h03FF, 16'h0300);
    set_box(1, 200, 200, 210, 210);
    set_box(3, 5, 5, 3, 10);
    send_tbl(0, 126);
    send_byte(byte_of(127), 1'b1, 1'b0);
    @(posedge clk); #1;
    cmp("b_same_cycle_num", int'(num_boxes), 1);
    @(negedge clk);
    chk_pix("b_old_table", 205, 200, 1'b1, 1, 2, 3);
    pulse_fs();
    cmp("b_num", int'(num_boxes), 2);
    chk_pix("b_639_479", 639, 479, 1'b1, 255, 0, 0);
    chk_pix("b_0_0", 0, 0, 1'b1, 255, 0, 0);
    chk_pix("b_5_5_invalid_box", 5, 5, 1'b1, 1, 2, 3);
    chk_pix("b_320_240", 320, 240, 1'b1, 1, 2, 3);

    // Table C: restart after 70 bytes, start colliding with a byte
    clr_tbl();
    set_box(2, 30, 30, 40, 40);
    send_tbl(0, 69);
    send_byte(8'hAA, 1'b0, 1'b1);
    cmp("c_restart_cnt", int'(byte_cnt), 0);
    pulse_fs();
    cmp("c_no_pending", int'(num_boxes), 2);
    send_tbl(0, 126);
    pulse_fs();
    cmp("c_127_no_swap", int'(num_boxes), 2);
    chk_pix("c_kept_old", 639, 479, 1'b1, 255, 0, 0);
    send_tbl(127, 127);
    pulse_fs();
    cmp("c_num", int'(num_boxes), 1);
    c = col(2);
    chk_pix("c_30_35", 30, 35, 1'b1, (c >> 16) & 255, (c >> 8) & 255, c & 255);
    chk_pix("c_old_gone", 639, 479, 1'b1, 1, 2, 3);

    // Table D: boxes 1 and 2 overlap at (120,120)
    clr_tbl();
    set_box(1, 100, 100, 120, 120);
    set_box(2, 120, 120, 140, 140);
    send_tbl(0, 127);
    pulse_fs();
    cmp("d_num", int'(num_boxes), 2);
`ifdef BBOX_LABEL_COLOR_EN
    chk_pix("d_overlap", 120, 120, 1'b1, 0, 255, 0);
`else
    chk_pix("d_overlap", 120, 120, 1'b1, 255, 0, 0);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
